opal_serial_rx: RTL and testbench

OPAL_SERIAL_RX -- requirements
Module: opal_serial_rx

---
 rtl/opal_pkg.sv | 14 +
 rtl/opal_sync.sv | 29 ++
 rtl/opal_serial_rx.sv | 159 +++++++++++++++
 tb/tb_opal_serial_rx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/opal_pkg.sv
// Shared definitions for the OPAL serial receiver slice: FSM state encoding
// and the default channel count / frame width.
package opal_pkg;

  localparam int OPAL_N_CH  = 16;
  localparam int OPAL_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } opal_state_e;

endpackage

// File: rtl/opal_sync.sv
// Multi-stage synchronizer for a bus of independent asynchronous bits, plus
// one extra registered copy of the synchronized value for edge detection.
module opal_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] sync_q,
  output logic [W-1:0] prev_q
);

  logic [STAGES-1:0][W-1:0] chain;

  // Shift raw inputs through the synchronizer chain and keep one delayed copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain  <= '0;
      prev_q <= '0;
    end else begin
      chain  <= {chain[STAGES-2:0], din};
      prev_q <= chain[STAGES-1];
    end
  end

  assign sync_q = chain[STAGES-1];

endmodule

// File: rtl/opal_serial_rx.sv
// Multi-channel serial frame receiver. A frame is bracketed by the enable
// line; every serial-clock rising edge inside it shifts one bit per channel.
// A frame is committed only if exactly WIDTH bits were received.
module opal_serial_rx
  import opal_pkg::*;
#(
  parameter int N_CH        = OPAL_N_CH,
  parameter int WIDTH       = OPAL_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int MSB_FIRST   = 1
) (
  input  logic                   CLK100MHz,
  input  logic                   ARESETN,
  input  logic [N_CH+1:0]        i_data,
  output logic [N_CH*WIDTH-1:0]  o_data,
  output logic                   o_valid,
  output logic                   o_frame_err,
  output logic [15:0]            o_frame_cnt,
  output logic [7:0]             o_err_cnt
);

  localparam int CW   = $clog2(WIDTH + 2);
  localparam int WARM = SYNC_STAGES + 2;
  localparam int WW   = $clog2(WARM + 1);

  logic [N_CH+1:0] sync_d;
  logic [N_CH+1:0] prev_d;
  logic            unused_prev;

  logic            sclk_rise, en_rise, en_fall;
  logic            sclk_rise_q, en_rise_q, en_fall_q;
  logic [N_CH-1:0] bits_q;
  logic [WW-1:0]   warm_cnt;
  logic            warm_done;
  logic            pend_q;

  opal_state_e     state_q, state_d;
  logic            start_frame, shift_en, commit;
  logic            frame_good;

  logic [N_CH-1:0][WIDTH-1:0] sh_q;
  logic [CW-1:0]   bit_cnt_q;
  logic [15:0]     frame_cnt_q;
  logic [7:0]      err_cnt_q;

  opal_sync #(
    .W      (N_CH + 2),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (CLK100MHz),
    .rst_n  (ARESETN),
    .din    (i_data),
    .sync_q (sync_d),
    .prev_q (prev_d)
  );

  assign unused_prev = ^prev_d[N_CH-1:0];

  assign sclk_rise = sync_d[N_CH+1] & ~prev_d[N_CH+1];
  assign en_rise   = sync_d[N_CH]   & ~prev_d[N_CH];
  assign en_fall   = ~sync_d[N_CH]  &  prev_d[N_CH];
  assign warm_done = (warm_cnt == WW'(WARM));

  // Register edge flags with their data bits; edges are suppressed until the
  // synchronizer has flushed after reset, so a line already high is no edge.
  always_ff @(posedge CLK100MHz or negedge ARESETN) begin
    if (!ARESETN) begin
      warm_cnt    <= '0;
      sclk_rise_q <= 1'b0;
      en_rise_q   <= 1'b0;
      en_fall_q   <= 1'b0;
      bits_q      <= '0;
    end else begin
      if (!warm_done) warm_cnt <= warm_cnt + WW'(1);
      sclk_rise_q <= sclk_rise & warm_done;
      en_rise_q   <= en_rise & warm_done;
      en_fall_q   <= en_fall & warm_done;
      bits_q      <= sync_d[N_CH-1:0];
    end
  end

  // FSM state register plus memory of an enable rise that landed in COMMIT.
  always_ff @(posedge CLK100MHz or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= (state_q == ST_COMMIT) && en_rise_q;
    end
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    commit      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_rise_q || pend_q) begin
          state_d     = ST_SHIFT;
          start_frame = 1'b1;
        end
      end
      ST_SHIFT: begin
        shift_en = sclk_rise_q;
        if (en_fall_q) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign frame_good = (bit_cnt_q == CW'(WIDTH));

  // Shift registers, bit counter, committed output and frame statistics.
  always_ff @(posedge CLK100MHz or negedge ARESETN) begin
    if (!ARESETN) begin
      sh_q        <= '0;
      bit_cnt_q   <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      if (start_frame) begin
        sh_q      <= '0;
        bit_cnt_q <= '0;
      end else if (shift_en) begin
        for (int k = 0; k < N_CH; k++) begin
          if (MSB_FIRST != 0) sh_q[k] <= {sh_q[k][WIDTH-2:0], bits_q[k]};
          else                sh_q[k] <= {bits_q[k], sh_q[k][WIDTH-1:1]};
        end
        if (bit_cnt_q != CW'(WIDTH + 1)) bit_cnt_q <= bit_cnt_q + CW'(1);
      end
      if (commit) begin
        if (frame_good) begin
          o_data      <= sh_q;
          o_valid     <= 1'b1;
          frame_cnt_q <= frame_cnt_q + 16'd1;
        end else begin
          o_frame_err <= 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end
      end
    end
  end

  assign o_frame_cnt = frame_cnt_q;
  assign o_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_opal_serial_rx.sv
// Scoreboard bench for opal_serial_rx: one MSB-first and one LSB-first
// instance share the same serial lines; expected frames are queued when the
// enable falls and popped by per-instance monitors on each output pulse.
module tb_opal_serial_rx;

  localparam int N_CH = 16;
  localparam int WIDTH = 16;
  localparam int S = 2;
  localparam int PH = 4;

  typedef struct {
    logic         is_err;
    logic [255:0] data;
    logic [15:0]  fc;
    logic [7:0]   ec;
    longint       cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [N_CH+1:0] i_data;

  logic [255:0] msb_data, lsb_data;
  logic msb_valid, lsb_valid, msb_err, lsb_err;
  logic [15:0] msb_fc, lsb_fc;
  logic [7:0] msb_ec, lsb_ec;

  exp_t q_msb[$];
  exp_t q_lsb[$];
  logic [15:0] tx_words [16];
  logic [15:0] exp_fc;
  logic [7:0] exp_ec;
  logic [255:0] last_msb, last_lsb;
  longint cycle = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  opal_serial_rx #(.N_CH(N_CH), .WIDTH(WIDTH), .SYNC_STAGES(S), .MSB_FIRST(1)) dut_msb (
    .CLK100MHz(clk), .ARESETN(rst_n), .i_data(i_data), .o_data(msb_data),
    .o_valid(msb_valid), .o_frame_err(msb_err), .o_frame_cnt(msb_fc), .o_err_cnt(msb_ec)
  );

  opal_serial_rx #(.N_CH(N_CH), .WIDTH(WIDTH), .SYNC_STAGES(S), .MSB_FIRST(0)) dut_lsb (
    .CLK100MHz(clk), .ARESETN(rst_n), .i_data(i_data), .o_data(lsb_data),
    .o_valid(lsb_valid), .o_frame_err(lsb_err), .o_frame_cnt(lsb_fc), .o_err_cnt(lsb_ec)
  );

  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Queue the expected outcome of the frame whose enable falls at the next posedge.
  task automatic pushExpect(input int nbits);
    exp_t e;
    if (nbits == WIDTH) begin
      exp_fc = exp_fc + 16'd1;
      for (int k = 0; k < N_CH; k++) begin
        last_msb[k*16 +: 16] = tx_words[k];
        last_lsb[k*16 +: 16] = rev16(tx_words[k]);
      end
      e.is_err = 1'b0;
    end else begin
      if (exp_ec != 8'hFF) exp_ec = exp_ec + 8'd1;
      e.is_err = 1'b1;
    end
    e.fc = exp_fc;
    e.ec = exp_ec;
    e.cyc = cycle + 1 + S + 2;
    e.data = last_msb;
    q_msb.push_back(e);
    e.data = last_lsb;
    q_lsb.push_back(e);
  endtask

  task automatic setBits(input int i);
    for (int k = 0; k < N_CH; k++) i_data[k] = (i < WIDTH) ? tx_words[k][WIDTH-1-i] : 1'b0;
  endtask

  // One serial bit: data settles during the low phase, then a rising edge.
  task automatic shiftOne(input int i, input bit drop_en);
    setBits(i);
    waitCycles(PH);
    i_data[N_CH+1] = 1'b1;
    if (drop_en) begin
      i_data[N_CH] = 1'b0;
      pushExpect(i + 1);
    end
    waitCycles(PH);
    i_data[N_CH+1] = 1'b0;
  endtask

  task automatic applyStimulus(input int nbits, input bit same_end, input bit skip_start);
    if (!skip_start) begin
      @(negedge clk);
      i_data[N_CH+1] = 1'b0;
      i_data[N_CH] = 1'b1;
    end
    waitCycles(4);
    for (int i = 0; i < nbits; i++) shiftOne(i, same_end && (i == nbits - 1));
    if (!(same_end && nbits > 0)) begin
      waitCycles(PH);
      i_data[N_CH] = 1'b0;
      pushExpect(nbits);
    end
    waitCycles(10);
  endtask

  task automatic checkEvent(input int which, input logic v, input logic e,
                            input logic [255:0] d, input logic [15:0] fc, input logic [7:0] ec);
    exp_t x;
    string tag;
    tag = (which == 0) ? "msb" : "lsb";
    if (v && e) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s_exclusive: got valid=1 err=1, expected only one", tag);
    end
    if ((which == 0 && q_msb.size() == 0) || (which == 1 && q_lsb.size() == 0)) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s_unexpected: got output pulse at cycle %0d, expected none", tag, cycle);
    end else begin
      x = (which == 0) ? q_msb.pop_front() : q_lsb.pop_front();
      checkOutput({tag, "_kind"}, {254'b0, v, e}, x.is_err ? 256'd1 : 256'd2);
      checkOutput({tag, "_data"}, d, x.data);
      checkOutput({tag, "_frame_cnt"}, 256'(fc), 256'(x.fc));
      checkOutput({tag, "_err_cnt"}, 256'(ec), 256'(x.ec));
      checkOutput({tag, "_latency"}, 256'(cycle), 256'(x.cyc));
    end
  endtask

  // Monitors: compare each output pulse against the scoreboard.
  always @(negedge clk) if (rst_n && (msb_valid || msb_err)) checkEvent(0, msb_valid, msb_err, msb_data, msb_fc, msb_ec);
  always @(negedge clk) if (rst_n && (lsb_valid || lsb_err)) checkEvent(1, lsb_valid, lsb_err, lsb_data, lsb_fc, lsb_ec);

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_msb_data"}, msb_data, 256'd0);
    checkOutput({tag, "_lsb_data"}, lsb_data, 256'd0);
    checkOutput({tag, "_pulses"}, 256'({msb_valid, msb_err, lsb_valid, lsb_err}), 256'd0);
    checkOutput({tag, "_frame_cnt"}, 256'({msb_fc, lsb_fc}), 256'd0);
    checkOutput({tag, "_err_cnt"}, 256'({msb_ec, lsb_ec}), 256'd0);
  endtask

  initial begin
    i_data = '0;
    rst_n = 1'b0;
    exp_fc = '0;
    exp_ec = '0;
    last_msb = '0;
    last_lsb = '0;
    waitCycles(3);
    checkResetState("reset");
    rst_n = 1'b1;
    waitCycles(8);

    // Frame A: channel k = 0x1000 + k.
    for (int k = 0; k < N_CH; k++) tx_words[k] = 16'h1000 + 16'(k);
    applyStimulus(16, 0, 0);

    // Frame B: channel 0 stream 1,0,...,0.
    for (int k = 0; k < N_CH; k++) tx_words[k] = (k == 0) ? 16'h8000 : (16'hA5A5 ^ (16'(k) * 16'h0111));
    applyStimulus(16, 0, 0);

    // Short and long frames are rejected.
    for (int k = 0; k < N_CH; k++) tx_words[k] = 16'hFFFF;
    applyStimulus(15, 0, 0);
    applyStimulus(18, 0, 0);

    // Last serial edge and enable fall in the same cycle.
    for (int k = 0; k < N_CH; k++) tx_words[k] = 16'h5A00 + 16'(k) * 16'h0013;
    applyStimulus(16, 1, 0);

    // Enable re-rises one cycle after falling: rejected empty frame, then a good one.
    @(negedge clk);
    i_data[N_CH] = 1'b1;
    waitCycles(8);
    i_data[N_CH] = 1'b0;
    pushExpect(0);
    @(negedge clk);
    i_data[N_CH] = 1'b1;
    for (int k = 0; k < N_CH; k++) tx_words[k] = ~(16'h1000 + 16'(k));
    applyStimulus(16, 0, 1);

    // Reset mid-frame with enable still high at release.
    @(negedge clk);
    i_data[N_CH] = 1'b1;
    waitCycles(4);
    for (int i = 0; i < 8; i++) shiftOne(i, 1'b0);
    rst_n = 1'b0;
    waitCycles(2);
    exp_fc = '0;
    exp_ec = '0;
    last_msb = '0;
    last_lsb = '0;
    checkResetState("midreset");
    rst_n = 1'b1;
    waitCycles(12);
    i_data[N_CH] = 1'b0;
    waitCycles(8);
    for (int k = 0; k < N_CH; k++) tx_words[k] = 16'h0F0F ^ (16'(k) << 4);
    applyStimulus(16, 0, 0);

    // Frame counter wrap from 0xFFFF.
    force dut_msb.frame_cnt_q = 16'hFFFF;
    force dut_lsb.frame_cnt_q = 16'hFFFF;
    #1;
    release dut_msb.frame_cnt_q;
    release dut_lsb.frame_cnt_q;
    exp_fc = 16'hFFFF;
    for (int k = 0; k < N_CH; k++) tx_words[k] = 16'hFFFF - 16'(k);
    applyStimulus(16, 0, 0);

    // Error counter saturation.
    for (int n = 0; n < 260; n++) applyStimulus(0, 0, 0);

    waitCycles(20);
    checkOutput("final_frame_cnt", 256'(msb_fc), 256'h0000);
    checkOutput("final_err_cnt", 256'(msb_ec), 256'hFF);
    checkOutput("msb_drained", 256'(q_msb.size()), 256'd0);
    checkOutput("lsb_drained", 256'(q_lsb.size()), 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
